dma_axi_sub: RTL

- AXI4 subordinate (responder) that terminates DMA bursts and turns each beat into a single-word access on the team's native memory interface (valid/address/wdata/wstrb/rdata/ready).
- Sits between the AXI interconnect and a native-port RAM or peripheral, as the counterpart of the DMA AXI master.
- Serves one transaction at a time: either a write burst or a read burst.

---
 rtl/dma_axi_sub_pkg.sv | 31 +++
 rtl/dma_axi_sub_addr_gen.sv | 60 ++++++
 rtl/dma_axi_sub.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/dma_axi_sub_pkg.sv
// Shared definitions for the DMA AXI4 subordinate: FSM encoding, AXI burst and
// response encodings, and the per-beat address advance rule.
package dma_axi_sub_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_DATA = 3'd1,
        ST_WR_RESP = 3'd2,
        ST_RD_MEM  = 3'd3,
        ST_RD_DATA = 3'd4
    } state_t;

    localparam logic [1:0] BURST_FIXED = 2'd0;
    localparam logic [1:0] BURST_INCR  = 2'd1;
    localparam logic [1:0] BURST_WRAP  = 2'd2;

    localparam logic [1:0] RESP_OKAY   = 2'd0;
    localparam logic [1:0] RESP_SLVERR = 2'd2;

    // Next beat address on a 64-bit carrier; callers truncate to their width,
    // which gives modulo-2^N wrap for free. Only INCR moves; everything else holds.
    function automatic logic [63:0] next_addr(input logic [63:0] addr,
                                              input logic [2:0]  size,
                                              input logic [1:0]  burst);
        if (burst == BURST_INCR)
            return addr + (64'd1 << size);
        else
            return addr;
    endfunction

endpackage

// File: rtl/dma_axi_sub_addr_gen.sv
// Beat address register and beat counter shared by the write and read paths.
// load captures a new burst, step advances one beat, last flags counter == len.
module dma_axi_sub_addr_gen
    import dma_axi_sub_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int LEN_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic              i_step,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [LEN_W-1:0]  i_len,
    input  logic [2:0]        i_size,
    input  logic [1:0]        i_burst,
    output logic [ADDR_W-1:0] o_addr,
    output logic [LEN_W-1:0]  o_cnt,
    output logic              o_last
);

    logic [ADDR_W-1:0] r_addr;
    logic [LEN_W-1:0]  r_cnt;
    logic [LEN_W-1:0]  r_len;
    logic [2:0]        r_size;
    logic [1:0]        r_burst;

    logic [63:0]        w_next64;
    logic [ADDR_W-1:0]  w_next;
    logic [63-ADDR_W:0] w_unused_hi;

    assign w_next64    = next_addr({{(64-ADDR_W){1'b0}}, r_addr}, r_size, r_burst);
    assign w_next      = w_next64[ADDR_W-1:0];
    assign w_unused_hi = w_next64[63:ADDR_W];

    // Burst capture on load, one-beat advance on step.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_addr  <= '0;
            r_cnt   <= '0;
            r_len   <= '0;
            r_size  <= '0;
            r_burst <= '0;
        end else if (i_load) begin
            r_addr  <= i_addr;
            r_cnt   <= '0;
            r_len   <= i_len;
            r_size  <= i_size;
            r_burst <= i_burst;
        end else if (i_step) begin
            r_addr  <= w_next;
            r_cnt   <= r_cnt + 1'b1;
        end
    end

    assign o_addr = r_addr;
    assign o_cnt  = r_cnt;
    assign o_last = (r_cnt == r_len);

endmodule

// File: rtl/dma_axi_sub.sv
// AXI4 subordinate terminating DMA bursts onto a single-word native port.
// One transaction at a time; read/write contention resolved round-robin.
// Optional: DMA_AXI_SUB_4K_CHECK_EN flags INCR bursts that cross 4 KiB as SLVERR.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | arbitrate AW/AR, latch burst, pick error flag
// ST_WR_DATA | one native write per W beat (drained when in error)
// ST_WR_RESP | present B response until bready
// ST_RD_MEM  | native read of the current beat (skipped when in error)
// ST_RD_DATA | present R beat until rready
module dma_axi_sub
    import dma_axi_sub_pkg::*;
#(
    parameter int AXI_ADDR_W = 32,
    parameter int AXI_DATA_W = 32,
    parameter int AXI_ID_W   = 1,
    parameter int AXI_LEN_W  = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [AXI_ID_W-1:0]     s_axi_awid,
    input  logic [AXI_ADDR_W-1:0]   s_axi_awaddr,
    input  logic [AXI_LEN_W-1:0]    s_axi_awlen,
    input  logic [2:0]              s_axi_awsize,
    input  logic [1:0]              s_axi_awburst,
    input  logic                    s_axi_awlock,
    input  logic [3:0]              s_axi_awcache,
    input  logic [2:0]              s_axi_awprot,
    input  logic [3:0]              s_axi_awqos,
    input  logic                    s_axi_awvalid,
    output logic                    s_axi_awready,
    input  logic [AXI_DATA_W-1:0]   s_axi_wdata,
    input  logic [AXI_DATA_W/8-1:0] s_axi_wstrb,
    input  logic                    s_axi_wlast,
    input  logic                    s_axi_wvalid,
    output logic                    s_axi_wready,
    output logic [AXI_ID_W-1:0]     s_axi_bid,
    output logic [1:0]              s_axi_bresp,
    output logic                    s_axi_bvalid,
    input  logic                    s_axi_bready,
    input  logic [AXI_ID_W-1:0]     s_axi_arid,
    input  logic [AXI_ADDR_W-1:0]   s_axi_araddr,
    input  logic [AXI_LEN_W-1:0]    s_axi_arlen,
    input  logic [2:0]              s_axi_arsize,
    input  logic [1:0]              s_axi_arburst,
    input  logic                    s_axi_arlock,
    input  logic [3:0]              s_axi_arcache,
    input  logic [2:0]              s_axi_arprot,
    input  logic [3:0]              s_axi_arqos,
    input  logic                    s_axi_arvalid,
    output logic                    s_axi_arready,
    output logic [AXI_ID_W-1:0]     s_axi_rid,
    output logic [AXI_DATA_W-1:0]   s_axi_rdata,
    output logic [1:0]              s_axi_rresp,
    output logic                    s_axi_rlast,
    output logic                    s_axi_rvalid,
    input  logic                    s_axi_rready,
    output logic                    valid,
    output logic [AXI_ADDR_W-1:0]   address,
    output logic [AXI_DATA_W-1:0]   wdata,
    output logic [AXI_DATA_W/8-1:0] wstrb,
    input  logic [AXI_DATA_W-1:0]   rdata,
    input  logic                    ready
);

    localparam int STRB_W    = AXI_DATA_W / 8;
    localparam int BYTE_LOG2 = $clog2(STRB_W);
    localparam logic [AXI_ADDR_W-1:0] ALIGN_MASK = ~AXI_ADDR_W'(STRB_W - 1);

    state_t                r_state;
    logic                  r_prio_wr;   // 0: read wins contention, 1: write wins
    logic                  r_err;
    logic [AXI_ID_W-1:0]   r_id;
    logic [1:0]            r_bresp;
    logic [1:0]            r_rresp;
    logic [AXI_DATA_W-1:0] r_rdata;

    logic                  w_idle;
    logic                  w_grant_rd;
    logic                  w_grant_wr;
    logic                  w_accept;
    logic [AXI_ADDR_W-1:0] w_ld_addr;
    logic [AXI_LEN_W-1:0]  w_ld_len;
    logic [2:0]            w_ld_size;
    logic [1:0]            w_ld_burst;
    logic [AXI_ID_W-1:0]   w_ld_id;
    logic                  w_ld_err;
    logic                  w_wr_hs;
    logic                  w_wlast_bad;
    logic                  w_step;
    logic                  w_last;
    logic [AXI_ADDR_W-1:0] w_beat_addr;
    logic [AXI_LEN_W-1:0]  w_cnt;
    logic                  w_unused_sideband;

    assign w_unused_sideband = ^{s_axi_awlock, s_axi_awcache, s_axi_awprot, s_axi_awqos,
                                 s_axi_arlock, s_axi_arcache, s_axi_arprot, s_axi_arqos, w_cnt};

    assign w_idle     = (r_state == ST_IDLE);
    assign w_grant_rd = s_axi_arvalid & (~s_axi_awvalid | ~r_prio_wr);
    assign w_grant_wr = s_axi_awvalid & (~s_axi_arvalid |  r_prio_wr);
    assign w_accept   = w_idle & (w_grant_rd | w_grant_wr);

    assign s_axi_arready = w_idle & w_grant_rd;
    assign s_axi_awready = w_idle & w_grant_wr;

    assign w_ld_addr  = w_grant_rd ? s_axi_araddr  : s_axi_awaddr;
    assign w_ld_len   = w_grant_rd ? s_axi_arlen   : s_axi_awlen;
    assign w_ld_size  = w_grant_rd ? s_axi_arsize  : s_axi_awsize;
    assign w_ld_burst = w_grant_rd ? s_axi_arburst : s_axi_awburst;
    assign w_ld_id    = w_grant_rd ? s_axi_arid    : s_axi_awid;

`ifdef DMA_AXI_SUB_4K_CHECK_EN
    localparam int SPAN_W = AXI_LEN_W + 9;
    logic [SPAN_W-1:0] w_span;
    logic              w_4k_err;
    assign w_span   = (SPAN_W'(w_ld_len) + SPAN_W'(1)) << w_ld_size;
    assign w_4k_err = (w_ld_burst == BURST_INCR) &&
                      ((SPAN_W'(w_ld_addr[11:0]) + w_span) > SPAN_W'(4096));
    assign w_ld_err = w_ld_burst[1] | (int'(w_ld_size) > BYTE_LOG2) | w_4k_err;
`else
    // WRAP and the reserved encoding both have bit 1 set.
    assign w_ld_err = w_ld_burst[1] | (int'(w_ld_size) > BYTE_LOG2);
`endif

    assign w_wr_hs     = (r_state == ST_WR_DATA) & s_axi_wvalid & s_axi_wready;
    assign w_wlast_bad = (s_axi_wlast != w_last);
    assign w_step      = (w_wr_hs & ~w_last) |
                         ((r_state == ST_RD_DATA) & s_axi_rready & ~w_last);

    dma_axi_sub_addr_gen #(
        .ADDR_W (AXI_ADDR_W),
        .LEN_W  (AXI_LEN_W)
    ) u_addr_gen (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_accept),
        .i_step  (w_step),
        .i_addr  (w_ld_addr),
        .i_len   (w_ld_len),
        .i_size  (w_ld_size),
        .i_burst (w_ld_burst),
        .o_addr  (w_beat_addr),
        .o_cnt   (w_cnt),
        .o_last  (w_last)
    );

    // Transaction sequencing, arbitration priority and response registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= ST_IDLE;
            r_prio_wr <= 1'b0;
            r_err     <= 1'b0;
            r_id      <= '0;
            r_bresp   <= RESP_OKAY;
            r_rresp   <= RESP_OKAY;
            r_rdata   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_id      <= w_ld_id;
                        r_err     <= w_ld_err;
                        r_prio_wr <= ~r_prio_wr;
                        r_state   <= w_grant_rd ? ST_RD_MEM : ST_WR_DATA;
                    end
                end
                ST_WR_DATA: begin
                    if (w_wr_hs) begin
                        if (w_wlast_bad)
                            r_err <= 1'b1;
                        if (w_last) begin
                            r_bresp <= (r_err | w_wlast_bad) ? RESP_SLVERR : RESP_OKAY;
                            r_state <= ST_WR_RESP;
                        end
                    end
                end
                ST_WR_RESP: begin
                    if (s_axi_bready)
                        r_state <= ST_IDLE;
                end
                ST_RD_MEM: begin
                    if (r_err) begin
                        r_rdata <= '0;
                        r_rresp <= RESP_SLVERR;
                        r_state <= ST_RD_DATA;
                    end else if (ready) begin
                        r_rdata <= rdata;
                        r_rresp <= RESP_OKAY;
                        r_state <= ST_RD_DATA;
                    end
                end
                ST_RD_DATA: begin
                    if (s_axi_rready)
                        r_state <= w_last ? ST_IDLE : ST_RD_MEM;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign s_axi_wready = (r_state == ST_WR_DATA) & (r_err | ready);
    assign s_axi_bvalid = (r_state == ST_WR_RESP);
    assign s_axi_bresp  = r_bresp;
    assign s_axi_bid    = r_id;
    assign s_axi_rvalid = (r_state == ST_RD_DATA);
    assign s_axi_rlast  = s_axi_rvalid & w_last;
    assign s_axi_rdata  = r_rdata;
    assign s_axi_rresp  = r_rresp;
    assign s_axi_rid    = r_id;

    assign valid   = ~r_err & (((r_state == ST_WR_DATA) & s_axi_wvalid) | (r_state == ST_RD_MEM));
    assign address = w_beat_addr & ALIGN_MASK;
    assign wdata   = (r_state == ST_WR_DATA) ? s_axi_wdata : '0;
    assign wstrb   = (r_state == ST_WR_DATA) ? s_axi_wstrb : '0;

endmodule
